fft_sdf_ctrl: RTL and testbench
===============================

// Module: fft_sdf_ctrl
// PURPOSE
//  Sequencer for the radix-2^2 single-path delay-feedback FFT pipeline built from cascaded bfii stages.
//  Accepts a framed sample stream and drives each stage's en, control1_bit and control2_bit.
//  Drives the twiddle-ROM exponent between stage pairs and frames the output stream (valid/sof/eof/index).
//  Flushes the pipeline after the last input frame so every accepted frame is fully emitted.
// PARAMETERS
//  N_POINTS   16  FFT size; power of 4, >=16
//  NUM_ST     2   bfii stage count = log4(N_POINTS)
//  STAGE_LAT  1   registered latency of one stage (butterfly + twiddle multiply), cycles
//  CNT_W      4   log2(N_POINTS); derived, not overridden
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous reset, active-high
//  in_valid   in   1             input sample present
//  in_sof     in   1             input sample is index 0 of a frame
//  in_ready   out  1             controller accepts sample this cycle
//  st_en      out  1             common enable to all bfii stages
//  st_c1      out  NUM_ST        control1_bit per stage (bit s = stage s)
//  st_c2      out  NUM_ST        control2_bit per stage
//  zero_ins   out  1             datapath injects 0 instead of input sample (flush)
//  tw_exp     out  (NUM_ST-1)*CNT_W  twiddle exponent after stage s, packed, slice s
//  out_valid  out  1             pipeline output sample valid
//  out_sof    out  1             output sample is first of frame
//  out_eof    out  1             output sample is last of frame
//  out_idx    out  CNT_W         bit-reversed frequency index of output sample
//  busy       out  1             state != IDLE
//  err_sof    out  1             one-cycle pulse: in_sof seen at nonzero count
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready=1; state IDLE; all counters 0.
//  Latency L = (N_POINTS-1) + NUM_ST*STAGE_LAT cycles of st_en from sample n accepted to its output.
//  Accept: acc = in_valid & in_ready. st_en = acc | (state==FLUSH). Pipeline frozen when st_en=0.
//  in_cnt (CNT_W, wraps N-1->0) increments on acc. Stage s local count k_s = in_cnt - s*STAGE_LAT mod N.
//  st_c2[s] = k_s[CNT_W-1-2s]; st_c1[s] = k_s[CNT_W-2-2s]. Both are combinational from the registered counter.
//  tw_exp[s], s<NUM_ST-1:
//    M = N/4^s, m = k_{s+1}' mod M (count at twiddle input), q = m/(M/4), b = m mod (M/4).
//    exp = ({0,2,1,3}[q] * b * 4^s) mod N.
//  FSM:
//    IDLE: in_ready=1. Sample with in_sof -> accepted, in_cnt=1, go FILL. Samples without sof are dropped (no st_en).
//    FILL: fill_cnt counts st_en cycles; when it reaches L, go RUN and assert out_valid with that st_en.
//    RUN: out_valid = st_en. out_cnt increments per valid output; out_idx = bitrev(out_cnt).
//      out_sof when out_cnt==0; out_eof when out_cnt==N-1.
//      When in_cnt wraps to 0 and the next cycle has no in_valid&in_sof, go FLUSH.
//    FLUSH: in_ready=0, zero_ins=1, st_en=1 every cycle. Runs L cycles (out frame completes), then IDLE.
//      If in_valid&in_sof arrives during FLUSH it is held off (in_ready=0) until IDLE.
//  Stall in RUN/FILL mid-frame (in_valid=0): st_en=0, all counters and outputs hold; out_valid=0.
//  in_sof with in_cnt!=0: err_sof pulses, sample is accepted as index 0, in_cnt=1.
//    Partial frame is discarded: out_valid suppressed until the realigned frame reaches output.
//  Back-to-back frames: sof exactly at wrap keeps RUN, no bubble, out_eof followed next st_en by out_sof.
//  rst asserted mid-operation: state IDLE next cycle, counters and outputs cleared; in-flight data abandoned.
// TESTING
//  N=16: one frame sof+16 samples, no stalls -> first out_valid 17 cycles after sof (L=15+2).
//    out_idx = 0,8,4,12,2,... ; then FLUSH 17 cycles -> IDLE, busy=0.
//  Single frame: st_c2[0] toggles every 8 accepted samples; st_c1[0] every 4; st_c2[1] every 2; st_c1[1] every 1.
//    tw_exp[0] for k=0..15 = 0,0,0,0,0,2,4,6,0,1,2,3,0,3,6,9 (as counted at twiddle input).
//  Three back-to-back frames -> 48 contiguous out_valid; out_sof at 0,16,32; out_eof at 15,31,47; no err_sof.
//  in_valid low 3 cycles at sample 5 -> st_en low 3 cycles; outputs identical to the unstalled run, shifted 3 cycles.
//  in_sof at in_cnt=7 -> err_sof=1 one cycle; no out_sof for the broken frame; next full frame emits 16 correct outputs.
//  rst pulse during RUN at in_cnt=9 -> next cycle busy=0, out_valid=0, in_ready=1; a new sof frame then completes normally.

Source files
------------

// File: rtl/fft_sdf_ctrl.sv
// Control sequencer for a radix-2^2 SDF FFT built from cascaded bfii stages:
// stage controls, inter-stage twiddle exponents, output framing and end-of-stream flush.
module fft_sdf_ctrl #(
   parameter int N_POINTS  = 16,
   parameter int NUM_ST    = 2,
   parameter int STAGE_LAT = 1,
   parameter int CNT_W     = $clog2(N_POINTS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic                          in_sof,
   output logic                          in_ready,
   output logic                          st_en,
   output logic [NUM_ST-1:0]             st_c1,
   output logic [NUM_ST-1:0]             st_c2,
   output logic                          zero_ins,
   output logic [(NUM_ST-1)*CNT_W-1:0]   tw_exp,
   output logic                          out_valid,
   output logic                          out_sof,
   output logic                          out_eof,
   output logic [CNT_W-1:0]              out_idx,
   output logic                          busy,
   output logic                          err_sof
);

   localparam int LAT = (N_POINTS - 1) + NUM_ST * STAGE_LAT;
   localparam int FW  = $clog2(LAT + 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [FW-1:0]    fill_cnt_q, fill_cnt_d;
   logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
   logic             sof_in, active, wrap_flush, flush_now, acc, sof_err;
   logic             fill_done, en, ov, busy_w;

   function automatic logic [CNT_W-1:0] bitrev(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      for (int i = 0; i < CNT_W; i++) r[i] = v[CNT_W-1-i];
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] tw_calc(input logic [CNT_W-1:0] k, input int s);
      int mw, m, q, b, r;
      mw = CNT_W - 2 * s;
      m  = int'(k) & ((1 << mw) - 1);
      q  = m >> (mw - 2);
      b  = m & ((1 << (mw - 2)) - 1);
      case (q)
         0:       r = 0;
         1:       r = 2;
         2:       r = 1;
         default: r = 3;
      endcase
      return CNT_W'((r * b * (1 << (2 * s))) % N_POINTS);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         fill_cnt_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         fill_cnt_q  <= fill_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      sof_in      = in_valid && in_sof && !rst;
      active      = (state_q == FILL) || (state_q == RUN);
      // A frame boundary without a following sof starts the flush in that same cycle.
      wrap_flush  = active && (in_cnt_q == '0) && !sof_in && !rst;
      flush_now   = ((state_q == FLUSH) && !rst) || wrap_flush;
      acc         = !rst && (((state_q == IDLE) && sof_in) || (active && in_valid && !wrap_flush));
      sof_err     = active && sof_in && (in_cnt_q != '0);
      fill_done   = (fill_cnt_q == FW'(LAT));
      en          = acc || flush_now;
      ov          = en && fill_done && !sof_err;

      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      fill_cnt_d  = fill_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (en) in_cnt_d = in_cnt_q + 1'b1;
      if (en && !fill_done) fill_cnt_d = fill_cnt_q + 1'b1;
      if (ov) out_cnt_d = out_cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (acc) state_d = FILL;
         end
         FILL, RUN: begin
            if (sof_err) begin
               // Realign: restarting the fill count discards the partial frame.
               in_cnt_d   = CNT_W'(1);
               fill_cnt_d = FW'(1);
               out_cnt_d  = '0;
               state_d    = FILL;
            end else if (wrap_flush) begin
               state_d     = FLUSH;
               flush_cnt_d = FW'(1);
            end else if (ov) begin
               state_d = RUN;
            end
         end
         FLUSH: begin
            flush_cnt_d = flush_cnt_q + 1'b1;
            if (flush_cnt_q == FW'(LAT - 1)) begin
               state_d     = IDLE;
               in_cnt_d    = '0;
               out_cnt_d   = '0;
               fill_cnt_d  = '0;
               flush_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_w    = (state_q != IDLE);
   assign busy      = busy_w;
   assign in_ready  = (state_q != FLUSH);
   assign st_en     = en;
   assign zero_ins  = flush_now;
   assign out_valid = ov;
   assign out_sof   = ov && (out_cnt_q == '0);
   assign out_eof   = ov && (out_cnt_q == CNT_W'(N_POINTS - 1));
   assign out_idx   = bitrev(out_cnt_q);
   assign err_sof   = sof_err;

   // Stage s sees the sample stream s*STAGE_LAT cycles after stage 0.
   for (genvar s = 0; s < NUM_ST; s++) begin : g_st
      logic [CNT_W-1:0] k_s;
      assign k_s      = in_cnt_q - CNT_W'(s * STAGE_LAT);
      assign st_c2[s] = busy_w && k_s[CNT_W-1-2*s];
      assign st_c1[s] = busy_w && k_s[CNT_W-2-2*s];
   end

   for (genvar s = 0; s < NUM_ST - 1; s++) begin : g_tw
      logic [CNT_W-1:0] k_t;
      assign k_t = in_cnt_q - CNT_W'((s + 1) * STAGE_LAT);
      assign tw_exp[s*CNT_W +: CNT_W] = busy_w ? tw_calc(k_t, s) : '0;
   end

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Scoreboard bench for fft_sdf_ctrl (N=16): directed frames, stalls, sof error, mid-run reset.
module tb_fft_sdf_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_sof;
   logic       in_ready, st_en, zero_ins, out_valid, out_sof, out_eof, busy, err_sof;
   logic [1:0] st_c1, st_c2;
   logic [3:0] tw_exp, out_idx;

   typedef struct {
      int cyc;
      bit sof;
      bit eof;
      int idx;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   err_seen = 0;
   int   br_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
   int   tw_tab[16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};

   fft_sdf_ctrl #(.N_POINTS(16), .NUM_ST(2), .STAGE_LAT(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
      .st_en(st_en), .st_c1(st_c1), .st_c2(st_c2), .zero_ins(zero_ins), .tw_exp(tw_exp),
      .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof), .out_idx(out_idx),
      .busy(busy), .err_sof(err_sof)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
      end
   endtask

   task automatic drv(input bit v, input bit s);
      @(posedge clk);
      #1;
      in_valid = v;
      in_sof   = s;
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
      #3;
   endtask

   task automatic push_outs(input int base, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.cyc = base + k;
         e.sof = (k % 16 == 0);
         e.eof = (k % 16 == 15);
         e.idx = br_tab[k % 16];
         sb.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 300) begin
         @(posedge clk);
         #4;
         k++;
      end
      chk("idle_timeout_busy", int'(busy), 0);
   endtask

   // Monitor: every presented output sample is matched against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL out_unexpected at cycle %0d: idx=%0d sof=%0b eof=%0b, no output expected",
                        cyc, out_idx, out_sof, out_eof);
            end else begin
               e = sb.pop_front();
               if (e.cyc != cyc || out_sof !== e.sof || out_eof !== e.eof || int'(out_idx) != e.idx) begin
                  n_err++;
                  $display("FAIL out_sample: got cyc=%0d idx=%0d sof=%0b eof=%0b, expected cyc=%0d idx=%0d sof=%0b eof=%0b",
                           cyc, out_idx, out_sof, out_eof, e.cyc, e.idx, e.sof, e.eof);
               end
            end
         end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            n_err++;
            $display("FAIL out_missing at cycle %0d: out_valid=0, expected idx=%0d at cycle %0d", cyc, e.idx, e.cyc);
         end
         if (err_sof) err_seen++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0, c1, c2, jm;
      rst = 1'b1;
      in_valid = 1'b0;
      in_sof = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
      chk("reset_state",
          int'({in_ready, st_en, st_c1, st_c2, zero_ins, tw_exp, out_valid, out_sof, out_eof, out_idx, busy, err_sof}),
          1 << 19);

      // Single frame: stage controls, twiddles, latency, flush length
      drv(1, 1);
      c0 = cyc;
      push_outs(c0 + 17, 16);
      for (int j = 1; j < 16; j++) begin
         drv(1, 0);
         #3;
         jm = (j - 1) & 15;
         chk("st_c2", int'(st_c2), ((jm >> 1) & 1) * 2 + ((j >> 3) & 1));
         chk("st_c1", int'(st_c1), (jm & 1) * 2 + ((j >> 2) & 1));
         chk("tw_exp", int'(tw_exp), tw_tab[jm]);
      end
      drv(0, 0);
      #3;
      chk("flush_zero_ins", int'(zero_ins), 1);
      chk("flush_st_en", int'(st_en), 1);
      goto(c0 + 17);
      chk("flush_in_ready", int'(in_ready), 0);
      goto(c0 + 32);
      chk("flush_busy_last", int'(busy), 1);
      goto(c0 + 33);
      chk("flush_busy_done", int'(busy), 0);

      // Three back-to-back frames
      drv(1, 1);
      c0 = cyc;
      push_outs(c0 + 17, 48);
      for (int j = 1; j < 48; j++) drv(1, (j % 16) == 0);
      drv(0, 0);
      wait_idle();

      // Three-cycle stall before sample 5
      drv(1, 1);
      c0 = cyc;
      push_outs(c0 + 20, 16);
      for (int j = 1; j < 5; j++) drv(1, 0);
      for (int j = 0; j < 3; j++) begin
         drv(0, 0);
         #3;
         chk("stall_st_en", int'(st_en), 0);
         chk("stall_st_c1_hold", int'(st_c1), 1);
      end
      for (int j = 5; j < 16; j++) drv(1, 0);
      drv(0, 0);
      wait_idle();

      // sof arriving at in_cnt=7
      drv(1, 1);
      for (int j = 1; j < 7; j++) drv(1, 0);
      drv(1, 1);
      c1 = cyc;
      #3;
      chk("err_sof_pulse", int'(err_sof), 1);
      push_outs(c1 + 17, 16);
      drv(1, 0);
      #3;
      chk("err_sof_clear", int'(err_sof), 0);
      for (int j = 2; j < 16; j++) drv(1, 0);
      drv(0, 0);
      wait_idle();

      // Reset while running at in_cnt=9 of the second frame
      drv(1, 1);
      c0 = cyc;
      push_outs(c0 + 17, 8);
      for (int j = 1; j < 25; j++) drv(1, j == 16);
      @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b1;
      in_sof = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      #3;
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      drv(1, 1);
      c2 = cyc;
      push_outs(c2 + 17, 16);
      for (int j = 1; j < 16; j++) drv(1, 0);
      drv(0, 0);
      wait_idle();

      repeat (3) @(posedge clk);
      #4;
      chk("err_sof_count", err_seen, 1);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
